// File: rtl/ike_pkg.sv
// Shared definitions for the iterative divider: default width, FSM states, saturation value.
// No logic of its own, so no latency.
// No flow control of its own.
package ike_pkg;

    localparam int DIV_WIDTH = 16;

    localparam logic [DIV_WIDTH-1:0] DIV_SAT = {DIV_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_RND  = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring division step: shift the next dividend bit into the partial remainder, trial-subtract.
// Purely combinational, zero cycles.
// No flow control; the owning FSM decides when the step result is taken.
module div_step #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] prem_in,
    input  logic             dbit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_out,
    output logic             qbit
);

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;

    // Trial subtraction is one bit wider than the shifted value, so its MSB is a clean borrow flag.
    always_comb begin
        shifted  = {prem_in, dbit};
        trial    = {1'b0, shifted} - {2'b00, divisor};
        qbit     = ~trial[WIDTH+1];
        // When the trial fails, shifted < divisor and fits in WIDTH bits; on success so does the difference.
        prem_out = qbit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Shared iterative unsigned restoring divider, one quotient bit per clock (optional rounding: ROUND_EN).
// Busy for WIDTH cycles (WIDTH+1 with ROUND_EN, 1 on divide-by-zero), then a one-cycle Ready pulse.
// start is ignored while Busy; a start on the Ready cycle is accepted. Clients arbitrate externally.
module iter_divider
    import ike_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             Busy,
    output logic             Ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] rem,
    output logic             dbz
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    div_state_t       state;
    logic [WIDTH-1:0] dvd;       // dividend, shifted left so its MSB feeds each step
    logic [WIDTH-1:0] dvs;       // latched divisor
    logic [WIDTH-1:0] prem;      // partial remainder
    logic [WIDTH-1:0] quo;       // quotient bits collected so far
    logic [CW-1:0]    cnt;       // iterations left after the current one
    logic             zdiv;      // latched divisor was zero

    logic [WIDTH-1:0] step_prem;
    logic             step_q;
    logic [WIDTH-1:0] quo_next;

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .prem_in (prem),
        .dbit    (dvd[WIDTH-1]),
        .divisor (dvs),
        .prem_out(step_prem),
        .qbit    (step_q)
    );

    // Quotient after the current step, used both for the running register and the final result.
    always_comb begin
        quo_next = {quo[WIDTH-2:0], step_q};
    end

`ifdef ROUND_EN
    logic             round_up;
    logic [WIDTH-1:0] quo_rnd;

    // Round to nearest: bump the quotient when the remainder is at least half the divisor, saturating.
    always_comb begin
        round_up = ({prem, 1'b0} >= {1'b0, dvs});
        quo_rnd  = (round_up && (quo != {WIDTH{1'b1}})) ? quo + WIDTH'(1) : quo;
    end
`endif

    // Control FSM with registered Busy/Ready and held result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= DIV_IDLE;
            dvd    <= '0;
            dvs    <= '0;
            prem   <= '0;
            quo    <= '0;
            cnt    <= '0;
            zdiv   <= 1'b0;
            Busy   <= 1'b0;
            Ready  <= 1'b0;
            result <= '0;
            rem    <= '0;
            dbz    <= 1'b0;
        end else begin
            Ready <= 1'b0;
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        dvd   <= dividend;
                        dvs   <= divisor;
                        prem  <= '0;
                        quo   <= '0;
                        cnt   <= CW'(WIDTH - 1);
                        zdiv  <= (divisor == '0);
                        Busy  <= 1'b1;
                        state <= DIV_RUN;
                    end
                end
                DIV_RUN: begin
                    if (zdiv) begin
                        // No iterations: report saturated quotient and pass the dividend back as remainder.
                        result <= {WIDTH{1'b1}};
                        rem    <= dvd;
                        dbz    <= 1'b1;
                        Ready  <= 1'b1;
                        Busy   <= 1'b0;
                        state  <= DIV_IDLE;
                    end else begin
                        prem <= step_prem;
                        quo  <= quo_next;
                        dvd  <= {dvd[WIDTH-2:0], 1'b0};
                        cnt  <= cnt - CW'(1);
                        if (cnt == '0) begin
`ifdef ROUND_EN
                            state <= DIV_RND;
`else
                            // Last step lands straight in the outputs so Busy spans exactly WIDTH cycles.
                            result <= quo_next;
                            rem    <= step_prem;
                            dbz    <= 1'b0;
                            Ready  <= 1'b1;
                            Busy   <= 1'b0;
                            state  <= DIV_IDLE;
`endif
                        end
                    end
                end
                DIV_RND: begin
`ifdef ROUND_EN
                    result <= quo_rnd;
                    rem    <= prem;
                    dbz    <= 1'b0;
                    Ready  <= 1'b1;
`endif
                    Busy   <= 1'b0;
                    state  <= DIV_IDLE;
                end
                default: begin
                    Busy  <= 1'b0;
                    state <= DIV_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Randomised and directed checks of iter_divider against an arithmetic reference model.
// Latency is measured in Busy cycles sampled on the falling edge.
// Every wait on the DUT is bounded by a cycle budget.
module tb_iter_divider;

    localparam int W = 16;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         Busy;
    logic         Ready;
    logic [W-1:0] result;
    logic [W-1:0] rem;
    logic         dbz;

    int errors = 0;
    int checks = 0;

    iter_divider #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .dividend(dividend),
        .divisor (divisor),
        .Busy    (Busy),
        .Ready   (Ready),
        .result  (result),
        .rem     (rem),
        .dbz     (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // Reference model straight from the arithmetic definition.
    task automatic model(input int unsigned a, input int unsigned b,
                         output int unsigned q, output int unsigned r,
                         output int unsigned z, output int unsigned lat);
        if (b == 0) begin
            q = 32'h0000_FFFF; r = a; z = 1; lat = 1;
        end else begin
            q = a / b; r = a % b; z = 0; lat = W;
`ifdef ROUND_EN
            lat = W + 1;
            if ((2 * r >= b) && (q != 32'h0000_FFFF)) q = q + 1;
`endif
        end
    endtask

    // Drive a start strobe for exactly one rising edge; call from a falling edge.
    task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Wait for Ready, counting Busy cycles, then compare against the model. Returns on the Ready falling edge.
    task automatic wait_done(input string tag, input int unsigned a, input int unsigned b);
        int unsigned q, r, z, lat;
        int          busy_cnt;
        bit          seen;
        model(a, b, q, r, z, lat);
        busy_cnt = 0;
        seen     = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (Ready) begin
                seen = 1;
                break;
            end
            if (Busy) busy_cnt++;
        end
        check({tag, " ready_seen"}, 32'(seen), 32'd1);
        check({tag, " busy_cycles"}, 32'(busy_cnt), lat);
        check({tag, " busy_at_ready"}, 32'(Busy), 32'd0);
        check({tag, " result"}, 32'(result), q);
        check({tag, " rem"}, 32'(rem), r);
        check({tag, " dbz"}, 32'(dbz), z);
    endtask

    task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        start_op(a, b);
        wait_done(tag, a, b);
        @(negedge clk);
        check({tag, " ready_pulse"}, 32'(Ready), 32'd0);
    endtask

    initial begin
        int pulses;
        int unsigned q, r, z, lat;
        logic [W-1:0] cap_res, cap_rem;
        logic [W-1:0] ra, rb;

        rst      = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(negedge clk);
        check("reset busy", 32'(Busy), 32'd0);
        check("reset ready", 32'(Ready), 32'd0);
        check("reset result", 32'(result), 32'd0);
        check("reset rem", 32'(rem), 32'd0);
        check("reset dbz", 32'(dbz), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_div("1000/7", 16'd1000, 16'd7);
        run_div("1234/0", 16'd1234, 16'd0);
        run_div("10/2", 16'd10, 16'd2);
        run_div("ffff/1", 16'hFFFF, 16'd1);
        run_div("5/9", 16'd5, 16'd9);
        run_div("ffff/ffff", 16'hFFFF, 16'hFFFF);
        run_div("0/3", 16'd0, 16'd3);

        // Second start while Busy must be ignored.
        start_op(16'd100, 16'd3);
        @(negedge clk);
        @(negedge clk);
        start_op(16'd50, 16'd5);
        pulses  = 0;
        cap_res = '0;
        cap_rem = '0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (Ready) begin
                pulses++;
                cap_res = result;
                cap_rem = rem;
            end
        end
        model(100, 3, q, r, z, lat);
        check("ignore pulses", 32'(pulses), 32'd1);
        check("ignore result", 32'(cap_res), q);
        check("ignore rem", 32'(cap_rem), r);

        // Back-to-back: new start issued on the Ready cycle.
        start_op(16'd77, 16'd8);
        wait_done("b2b first", 77, 8);
        start_op(16'd300, 16'd10);
        @(negedge clk);
        check("b2b ready_drop", 32'(Ready), 32'd0);
        check("b2b busy_rise", 32'(Busy), 32'd1);
        begin
            int busy_cnt;
            bit seen;
            busy_cnt = 1;
            seen     = 0;
            for (int i = 0; i < 60; i++) begin
                @(negedge clk);
                if (Ready) begin
                    seen = 1;
                    break;
                end
                if (Busy) busy_cnt++;
            end
            model(300, 10, q, r, z, lat);
            check("b2b ready_seen", 32'(seen), 32'd1);
            check("b2b busy_cycles", 32'(busy_cnt), lat);
            check("b2b result", 32'(result), q);
            check("b2b rem", 32'(rem), r);
        end
        @(negedge clk);

        // Asynchronous reset in the middle of a division.
        start_op(16'd1000, 16'd7);
        repeat (5) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("arst busy", 32'(Busy), 32'd0);
        check("arst ready", 32'(Ready), 32'd0);
        check("arst result", 32'(result), 32'd0);
        check("arst rem", 32'(rem), 32'd0);
        check("arst dbz", 32'(dbz), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (Ready || Busy) pulses++;
        end
        check("arst no_activity", 32'(pulses), 32'd0);
        run_div("8/4", 16'd8, 16'd4);

        // Random operands, biased towards small divisors and the occasional zero.
        for (int n = 0; n < 30; n++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 3))
                0:       rb = 16'd0;
                1:       rb = 16'($urandom_range(1, 15));
                2:       rb = 16'($urandom_range(1, 300));
                default: rb = 16'($urandom);
            endcase
            run_div($sformatf("rand%0d %0d/%0d", n, ra, rb), ra, rb);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
